stab_margin_detect: RTL and testbench

//  Consumes the per-frequency loop-gain samples (gain dB, phase) produced by the
//  AC/SP stability sweep of the amplifier bench. It locates the unity-gain and
//  -180 deg crossovers and reports phase margin, gain margin and a stability

---
 rtl/stab_margin_detect.sv | 220 ++++++++++++++++++++++
 tb/tb_stab_margin_detect.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stab_margin_detect.sv
// stab_margin_detect
//   Consumes the per-frequency loop-gain samples (gain in dB, phase) of one
//   stability sweep, finds the unity-gain (0 dB) and phase (-180 deg)
//   crossovers and reports phase margin, gain margin and a stability verdict
//   once per sweep.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   s_valid/s_ready   sample handshake; s_start / s_last frame the sweep
//   s_freq            sample frequency, unsigned Hz
//   s_gain            loop gain, signed Q8.8 dB
//   s_phase           loop phase, signed, 1/16 deg LSB (-180 deg = -2880)
//   r_valid/r_ready   result handshake; r_valid held until r_ready
//   r_ugf, r_pm       unity-gain crossover frequency, phase margin
//   r_pcf, r_gm       phase crossover frequency, gain margin
//   r_flags           {unstable, freq_err, cnt_sat, pcf_found, ugf_found}
//   r_count           samples accepted in the sweep (saturating)
module stab_margin_detect #(
  parameter int F_W   = 32,
  parameter int G_W   = 16,
  parameter int P_W   = 16,
  parameter int CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_start,
  input  logic                  s_last,
  input  logic [F_W-1:0]        s_freq,
  input  logic signed [G_W-1:0] s_gain,
  input  logic signed [P_W-1:0] s_phase,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [F_W-1:0]        r_ugf,
  output logic signed [P_W:0]   r_pm,
  output logic [F_W-1:0]        r_pcf,
  output logic signed [G_W:0]   r_gm,
  output logic [4:0]            r_flags,
  output logic [CNT_W-1:0]      r_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_e;

  localparam logic signed [P_W:0] PH_180 = (P_W+1)'(2880);

  // Phase relative to -180 deg, one bit wider so it never wraps.
  function automatic logic signed [P_W:0] ph_off(input logic signed [P_W-1:0] p);
    logic signed [P_W:0] e;
    e = {p[P_W-1], p};
    return e + PH_180;
  endfunction

  function automatic logic [P_W:0] ph_mag(input logic signed [P_W:0] v);
    return v[P_W] ? -v : v;
  endfunction

  function automatic logic [G_W:0] gain_mag(input logic signed [G_W-1:0] g);
    logic signed [G_W:0] e;
    e = {g[G_W-1], g};
    return e[G_W] ? -e : e;
  endfunction

  // Gain margin is the negated gain; the extra bit holds -(-2^(G_W-1)).
  function automatic logic signed [G_W:0] gm_calc(input logic signed [G_W-1:0] g);
    logic signed [G_W:0] e;
    e = {g[G_W-1], g};
    return -e;
  endfunction

  state_e                state_q, state_d;
  logic [F_W-1:0]        prev_freq_q, prev_freq_d;
  logic signed [G_W-1:0] prev_gain_q, prev_gain_d;
  logic signed [P_W-1:0] prev_phase_q, prev_phase_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ugf_found_q, ugf_found_d;
  logic [F_W-1:0]        ugf_freq_q, ugf_freq_d;
  logic signed [P_W:0]   pm_q, pm_d;
  logic                  pcf_found_q, pcf_found_d;
  logic [F_W-1:0]        pcf_freq_q, pcf_freq_d;
  logic signed [G_W:0]   gm_q, gm_d;
  logic                  freq_err_q, freq_err_d;
  logic                  cnt_sat_q, cnt_sat_d;

  logic                  accept;
  logic signed [P_W:0]   prev_off, cur_off;
  logic                  ugf_cross, pcf_cross;

  assign accept   = s_valid & s_ready;
  assign prev_off = ph_off(prev_phase_q);
  assign cur_off  = ph_off(s_phase);

  // 0 dB crossing: prev >= 0 and cur strictly negative.
  assign ugf_cross = ~prev_gain_q[G_W-1] & s_gain[G_W-1];
  // -180 deg crossing: prev strictly above, cur at or below.
  assign pcf_cross = (~prev_off[P_W] & (prev_off != '0)) & (cur_off[P_W] | (cur_off == '0));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_freq_q  <= '0;
      prev_gain_q  <= '0;
      prev_phase_q <= '0;
      count_q      <= '0;
      ugf_found_q  <= 1'b0;
      ugf_freq_q   <= '0;
      pm_q         <= '0;
      pcf_found_q  <= 1'b0;
      pcf_freq_q   <= '0;
      gm_q         <= '0;
      freq_err_q   <= 1'b0;
      cnt_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_freq_q  <= prev_freq_d;
      prev_gain_q  <= prev_gain_d;
      prev_phase_q <= prev_phase_d;
      count_q      <= count_d;
      ugf_found_q  <= ugf_found_d;
      ugf_freq_q   <= ugf_freq_d;
      pm_q         <= pm_d;
      pcf_found_q  <= pcf_found_d;
      pcf_freq_q   <= pcf_freq_d;
      gm_q         <= gm_d;
      freq_err_q   <= freq_err_d;
      cnt_sat_q    <= cnt_sat_d;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && s_start) state_d = s_last ? REPORT : SWEEP;
      SWEEP:   if (accept && s_last)  state_d = REPORT;
      REPORT:  if (r_ready)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- sweep accumulation ----
  always_comb begin
    prev_freq_d  = prev_freq_q;
    prev_gain_d  = prev_gain_q;
    prev_phase_d = prev_phase_q;
    count_d      = count_q;
    ugf_found_d  = ugf_found_q;
    ugf_freq_d   = ugf_freq_q;
    pm_d         = pm_q;
    pcf_found_d  = pcf_found_q;
    pcf_freq_d   = pcf_freq_q;
    gm_d         = gm_q;
    freq_err_d   = freq_err_q;
    cnt_sat_d    = cnt_sat_q;

    if (accept && s_start) begin
      // A start sample always opens a fresh sweep, even mid-sweep.
      count_d      = CNT_W'(1);
      ugf_found_d  = 1'b0;
      ugf_freq_d   = '0;
      pm_d         = '0;
      pcf_found_d  = 1'b0;
      pcf_freq_d   = '0;
      gm_d         = '0;
      freq_err_d   = 1'b0;
      cnt_sat_d    = 1'b0;
      prev_freq_d  = s_freq;
      prev_gain_d  = s_gain;
      prev_phase_d = s_phase;
    end else if (accept && state_q == SWEEP) begin
      if (count_q == '1) cnt_sat_d = 1'b1;
      else               count_d   = count_q + CNT_W'(1);

      if (s_freq <= prev_freq_q) freq_err_d = 1'b1;

      // Only the first crossing counts; the nearer sample wins, ties go to prev.
      if (!ugf_found_q && ugf_cross) begin
        ugf_found_d = 1'b1;
        if (gain_mag(prev_gain_q) <= gain_mag(s_gain)) begin
          ugf_freq_d = prev_freq_q;
          pm_d       = prev_off;
        end else begin
          ugf_freq_d = s_freq;
          pm_d       = cur_off;
        end
      end

      if (!pcf_found_q && pcf_cross) begin
        pcf_found_d = 1'b1;
        if (ph_mag(prev_off) <= ph_mag(cur_off)) begin
          pcf_freq_d = prev_freq_q;
          gm_d       = gm_calc(prev_gain_q);
        end else begin
          pcf_freq_d = s_freq;
          gm_d       = gm_calc(s_gain);
        end
      end

      prev_freq_d  = s_freq;
      prev_gain_d  = s_gain;
      prev_phase_d = s_phase;
    end
  end

  // ---- outputs ----
  always_comb begin
    s_ready = (state_q != REPORT);
    r_valid = (state_q == REPORT);
  end

  assign r_ugf   = ugf_freq_q;
  assign r_pm    = pm_q;
  assign r_pcf   = pcf_freq_q;
  assign r_gm    = gm_q;
  assign r_count = count_q;
  assign r_flags = {(ugf_found_q & pm_q[P_W]) | (pcf_found_q & gm_q[G_W]),
                    freq_err_q, cnt_sat_q, pcf_found_q, ugf_found_q};

endmodule

// File: tb/tb_stab_margin_detect.sv
// Testbench for stab_margin_detect: directed sweeps plus randomized sweeps,
// with a behavioural sweep model feeding a result scoreboard that a separate
// monitor drains whenever the DUT raises r_valid.
module tb_stab_margin_detect;
  localparam int F_W = 32, G_W = 16, P_W = 16, CNT_W = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid, s_ready, s_start, s_last;
  logic [F_W-1:0]        s_freq;
  logic signed [G_W-1:0] s_gain;
  logic signed [P_W-1:0] s_phase;
  logic                  r_valid, r_ready;
  logic [F_W-1:0]        r_ugf, r_pcf;
  logic signed [P_W:0]   r_pm;
  logic signed [G_W:0]   r_gm;
  logic [4:0]            r_flags;
  logic [CNT_W-1:0]      r_count;

  stab_margin_detect #(.F_W(F_W), .G_W(G_W), .P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_start(s_start), .s_last(s_last),
    .s_freq(s_freq), .s_gain(s_gain), .s_phase(s_phase),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_ugf(r_ugf), .r_pm(r_pm), .r_pcf(r_pcf), .r_gm(r_gm),
    .r_flags(r_flags), .r_count(r_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct packed {
    logic [31:0]        f;
    logic signed [15:0] g;
    logic signed [15:0] p;
  } smp_t;

  typedef struct packed {
    logic [31:0]        ugf;
    logic signed [31:0] pm;
    logic [31:0]        pcf;
    logic signed [31:0] gm;
    logic [4:0]         flags;
    logic [31:0]        count;
    logic [31:0]        cyc;
  } exp_t;

  smp_t sw[$];
  exp_t exp_q[$];
  bit   in_sweep = 0;
  bit   res_pending = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic chk_bits(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Result of a complete sweep, computed straight from the crossing rules.
  function automatic exp_t model();
    exp_t e;
    bit uf, pf, fe;
    smp_t a, b, k;
    int n;
    e = '0; uf = 0; pf = 0; fe = 0;
    n = sw.size();
    for (int i = 1; i < n; i++) begin
      a = sw[i-1];
      b = sw[i];
      if (b.f <= a.f) fe = 1;
      if (!uf && int'(a.g) >= 0 && int'(b.g) < 0) begin
        uf = 1;
        k = (iabs(int'(a.g)) <= iabs(int'(b.g))) ? a : b;
        e.ugf = k.f;
        e.pm  = int'(k.p) + 2880;
      end
      if (!pf && int'(a.p) > -2880 && int'(b.p) <= -2880) begin
        pf = 1;
        k = (iabs(int'(a.p) + 2880) <= iabs(int'(b.p) + 2880)) ? a : b;
        e.pcf = k.f;
        e.gm  = -int'(k.g);
      end
    end
    e.count = (n > 4095) ? 4095 : n;
    e.flags = {(uf && e.pm < 0) || (pf && e.gm < 0), fe, n > 4095, pf, uf};
    return e;
  endfunction

  task automatic send(input logic [31:0] f, input int g, input int p, input bit st, input bit ls);
    int t;
    smp_t s;
    exp_t e;
    t = 0;
    s_valid = 1'b1; s_freq = f; s_gain = 16'(g); s_phase = 16'(p);
    s_start = st; s_last = ls;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", s_ready, 1);
    end else begin
      @(posedge clk);
      #1;
      s.f = f; s.g = 16'(g); s.p = 16'(p);
      if (st) begin
        sw.delete();
        sw.push_back(s);
        in_sweep = 1;
      end else if (in_sweep) begin
        sw.push_back(s);
      end
      if (in_sweep && ls) begin
        e = model();
        e.cyc = cyc;
        exp_q.push_back(e);
        in_sweep = 0;
        res_pending = 1;
      end
    end
    s_valid = 1'b0; s_start = 1'b0; s_last = 1'b0;
  endtask

  task automatic take_result(input int hold, input bit strict);
    int t;
    t = 0;
    res_pending = 0;
    @(negedge clk);
    while (!r_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!r_valid) begin
      chk("result_timeout", r_valid, 1);
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (strict) begin
          chk("hold_s_ready", s_ready, 0);
          chk("hold_r_valid", r_valid, 1);
        end
      end
      @(posedge clk); #1;
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
      if (strict) begin
        chk("release_s_ready", s_ready, 1);
        chk("release_r_valid", r_valid, 0);
      end
    end
  endtask

  // Five-sample reference sweep; ph3 is the phase at 4 MHz.
  task automatic base_sweep(input int ph3);
    send(32'd1_000_000,  'h0A00, -1600, 1, 0);
    send(32'd2_000_000,  'h0500, -2000, 0, 0);
    send(32'd4_000_000,  'h0080, ph3,   0, 0);
    send(32'd8_000_000,  -256,   -2400, 0, 0);
    send(32'd16_000_000, -1280,  -2900, 0, 1);
  endtask

  task automatic rand_sweep();
    int n, g, p;
    logic [31:0] f;
    n = $urandom_range(1, 10);
    g = int'($urandom_range(0, 3000));
    p = -int'($urandom_range(0, 2600));
    f = $urandom_range(1, 1000) * 1000;
    for (int i = 0; i < n; i++) begin
      send(f, g, p, (i == 0) || ($urandom_range(0, 9) == 0), i == n - 1);
      if ($urandom_range(0, 9) == 0) f = f - $urandom_range(0, 2000);
      else                           f = f + $urandom_range(1, 50000);
      if (g > 0 && $urandom_range(0, 5) == 0) g = -g;
      else if ($urandom_range(0, 7) == 0)     g = 0;
      else                                    g = g - int'($urandom_range(0, 900));
      if ($urandom_range(0, 5) == 0) p = -2880;
      else                           p = p - int'($urandom_range(0, 500));
    end
    if (res_pending) take_result($urandom_range(0, 3), 0);
  endtask

  // Monitor: pops one expectation per result and checks stability while held.
  exp_t        mon_e;
  logic [114:0] snap;
  bit          pv = 0;
  always @(negedge clk) begin
    if (r_valid && !pv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", r_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ugf",     r_ugf,   mon_e.ugf);
        chk("pm",      r_pm,    mon_e.pm);
        chk("pcf",     r_pcf,   mon_e.pcf);
        chk("gm",      r_gm,    mon_e.gm);
        chk("flags",   r_flags, mon_e.flags);
        chk("count",   r_count, mon_e.count);
        chk("latency", cyc,     mon_e.cyc);
      end
      snap = {r_ugf, r_pm, r_pcf, r_gm, r_flags, r_count};
    end else if (r_valid && pv) begin
      chk_bits("stable", 128'({r_ugf, r_pm, r_pcf, r_gm, r_flags, r_count}), 128'(snap));
    end
    pv = r_valid;
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_start = 1'b0; s_last = 1'b0;
    s_freq = '0; s_gain = '0; s_phase = '0; r_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_ugf",     r_ugf,   0);
    chk("rst_pm",      r_pm,    0);
    chk("rst_gm",      r_gm,    0);
    chk("rst_flags",   r_flags, 0);
    chk("rst_count",   r_count, 0);

    // Reference sweep, then the unstable variant.
    base_sweep(-2240);
    take_result(1, 0);
    base_sweep(-3000);
    take_result(0, 0);

    // Single-sample sweep.
    send(32'd5_000, 100, -100, 1, 1);
    take_result(0, 0);

    // Restart at sample 3 of 6.
    for (int i = 0; i < 6; i++)
      send(32'(1000 * (i + 1)), 2000 - 600 * i, -2000 - 250 * i, (i == 0) || (i == 2), i == 5);
    take_result(2, 0);

    // Consumer stalls for 10 cycles.
    base_sweep(-2240);
    take_result(10, 1);

    // Non-monotonic frequencies.
    send(32'd1_000_000, 512, -1000, 1, 0);
    send(32'd3_000_000, 256, -1500, 0, 0);
    send(32'd2_000_000, -256, -2000, 0, 1);
    take_result(0, 0);

    // Reset mid-sweep aborts without a result.
    send(32'd1_000, 512, -1000, 1, 0);
    send(32'd2_000, 100, -2000, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sw.delete(); in_sweep = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_r_valid", r_valid, 0);
      chk("abort_s_ready", s_ready, 1);
    end
    send(32'd1_000, 300, -2000, 1, 0);
    send(32'd2_000, -300, -2880, 0, 1);
    take_result(0, 0);

    // Non-start sample in IDLE is dropped, then gain/phase ties and 0 dB last.
    send(32'd9_000, -500, -3000, 0, 1);
    send(32'd1_000, 256, -2800, 1, 0);
    send(32'd2_000, -256, -2960, 0, 1);
    take_result(0, 0);
    send(32'd1_000, 256, -2000, 1, 0);
    send(32'd2_000, 0, -2100, 0, 1);
    take_result(0, 0);

    // Sample counter saturation.
    for (int i = 0; i < 4100; i++)
      send(32'(i + 1), 100, -100, i == 0, i == 4099);
    take_result(0, 0);

    for (int k = 0; k < 60; k++) rand_sweep();

    repeat (5) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
